// File: rtl/dcache_controller.sv
// ---------------------------------------------------------------------------
// dcache_controller
//
// Controller for a direct-mapped, write-back, write-allocate L1 data cache.
// The cache holds 32 lines of 256 bits and serves a 32-bit CPU port. The tag
// and data arrays live outside this block as SRAMs with a combinational read
// and a negedge write. Lines move to and from off-chip memory over a 256-bit
// request/ack interface.
//
// Address split: offset = addr[4:0], index = addr[9:5], tag = addr[31:10].
// A tag entry is {valid, dirty, tag[21:0]}.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   p1_addr_i, p1_data_i   CPU byte address and store data
//   p1_MemRead_i           load request
//   p1_MemWrite_i          store request (takes priority over a load)
//   p1_data_o, p1_stall_o  load data and pipeline hold
//   tag_*                  tag SRAM index, read/write data, enable, write strobe
//   data_*                 data SRAM index, read/write data, enable, write strobe
//   mem_addr_o, mem_data_o line address and write-back line to memory
//   mem_enable_o           memory request active
//   mem_write_o            memory request is a write-back
//   mem_data_i, mem_ack_i  refill line and one-cycle acknowledge
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,

  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  input  logic         p1_MemRead_i,
  input  logic         p1_MemWrite_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,

  output logic [4:0]   tag_addr_o,
  input  logic [23:0]  tag_data_i,
  output logic [23:0]  tag_data_o,
  output logic         tag_enable_o,
  output logic         tag_write_o,

  output logic [4:0]   data_addr_o,
  input  logic [255:0] data_data_i,
  output logic [255:0] data_data_o,
  output logic         data_enable_o,
  output logic         data_write_o,

  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    ALLOCATE,
    REFILL
  } state_t;

  state_t state;
  state_t next_state;

  logic [21:0]  addr_tag;
  logic [4:0]   index;
  logic [2:0]   word_sel;
  logic [7:0]   word_bit;
  logic         line_valid;
  logic         line_dirty;
  logic [21:0]  stored_tag;
  logic         req;
  logic         hit;
  logic [255:0] merged_line;
  logic         unused_byte_offset;

  // The two byte-offset bits never select anything: the CPU port is word-wide.
  assign unused_byte_offset = ^p1_addr_i[1:0];

  assign addr_tag   = p1_addr_i[31:10];
  assign index      = p1_addr_i[9:5];
  assign word_sel   = p1_addr_i[4:2];
  assign word_bit   = {word_sel, 5'b00000};

  assign line_valid = tag_data_i[23];
  assign line_dirty = tag_data_i[22];
  assign stored_tag = tag_data_i[21:0];

  assign req = p1_MemRead_i | p1_MemWrite_i;
  assign hit = line_valid & (stored_tag == addr_tag);

  // The SRAMs are indexed straight from the CPU address; the CPU holds the
  // address steady for the whole miss, so the index stays valid throughout.
  assign tag_addr_o    = index;
  assign data_addr_o   = index;
  assign tag_enable_o  = req | (state != IDLE);
  assign data_enable_o = req | (state != IDLE);

  // Loads read the selected word out of whatever line the index points at;
  // the value is only meaningful on a hit, which is when the stall is low.
  assign p1_data_o = data_data_i[word_bit +: 32];

  // A write-back always sends the line currently held in the data SRAM.
  assign mem_data_o = data_data_i;

  // Stall while any miss work is in progress, and also in the very cycle a
  // miss is detected so the pipeline never sees stale load data.
  assign p1_stall_o = (state != IDLE) | (req & ~hit);

  // Store-hit data: the current line with one word replaced.
  always_comb begin
    merged_line = data_data_i;
    merged_line[word_bit +: 32] = p1_data_i;
  end

  // State register. Reset abandons any memory request in flight; since the
  // memory controls are decoded from this register they drop with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus all SRAM and memory controls. Memory enable,
  // write and address depend on the state only, never on mem_ack_i, so the
  // memory side sees no combinational loop through the acknowledge.
  always_comb begin
    next_state   = state;
    tag_write_o  = 1'b0;
    data_write_o = 1'b0;
    tag_data_o   = {2'b11, addr_tag};
    data_data_o  = merged_line;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'h0000_0000;

    case (state)
      IDLE: begin
        if (req && !hit) begin
          next_state = MISS;
        end
        // Store hits complete in the request cycle and mark the line dirty.
        // Held off during reset so a reset never leaves a stray SRAM write.
        if (p1_MemWrite_i && hit && !rst_i) begin
          tag_write_o  = 1'b1;
          data_write_o = 1'b1;
        end
      end

      MISS: begin
        next_state = line_dirty ? WRITEBACK : ALLOCATE;
      end

      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {stored_tag, index, 5'b00000};
        if (mem_ack_i) begin
          next_state = ALLOCATE;
        end
      end

      ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {addr_tag, index, 5'b00000};
        // Refill data is only valid in the ack cycle, so it is written to
        // the SRAMs right then; the line is clean until a store touches it.
        if (mem_ack_i) begin
          next_state   = REFILL;
          tag_write_o  = 1'b1;
          data_write_o = 1'b1;
          tag_data_o   = {2'b10, addr_tag};
          data_data_o  = mem_data_i;
        end
      end

      REFILL: begin
        // One cycle for the SRAM write to land before IDLE re-checks the tag.
        next_state = IDLE;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// ---------------------------------------------------------------------------
// tb_dcache_controller
//
// Bench for the data-cache controller. It supplies behavioural tag/data SRAMs
// (combinational read, negedge write, tag array cleared by reset) and a
// memory responder with a programmable ack latency. The reference is a flat
// word-addressed memory plus a record of which line each index holds, from
// which expected load data, stall length and memory traffic are derived.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dcache_controller;

  logic         clk;
  logic         rst;

  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;

  logic [4:0]   tag_addr_o;
  logic [23:0]  tag_data_i;
  logic [23:0]  tag_data_o;
  logic         tag_enable_o;
  logic         tag_write_o;

  logic [4:0]   data_addr_o;
  logic [255:0] data_data_i;
  logic [255:0] data_data_o;
  logic         data_enable_o;
  logic         data_write_o;

  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  dcache_controller dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .p1_addr_i     (p1_addr_i),
    .p1_data_i     (p1_data_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .tag_addr_o    (tag_addr_o),
    .tag_data_i    (tag_data_i),
    .tag_data_o    (tag_data_o),
    .tag_enable_o  (tag_enable_o),
    .tag_write_o   (tag_write_o),
    .data_addr_o   (data_addr_o),
    .data_data_i   (data_data_i),
    .data_data_o   (data_data_o),
    .data_enable_o (data_enable_o),
    .data_write_o  (data_write_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    int          stall;
  } exp_t;

  typedef struct {
    bit           write;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_exp_t;

  exp_t         exp_q[$];
  mem_exp_t     mem_q[$];

  int           n_compared = 0;
  int           n_failed   = 0;
  int           mem_latency = 1;
  logic [255:0] last_wb_data = '0;

  // Reference state: architectural memory, what memory itself should hold,
  // and which tag each index is expected to contain.
  logic [31:0]  ref_mem     [int unsigned];
  logic [31:0]  ref_backing [int unsigned];
  bit           m_valid [32];
  bit           m_dirty [32];
  logic [21:0]  m_tag   [32];

  // Memory responder's own storage, keyed by line number.
  logic [255:0] mem_store [int unsigned];

  // SRAM models.
  logic [23:0]  tag_mem  [32];
  logic [255:0] data_mem [32];

  assign tag_data_i  = tag_mem[tag_addr_o];
  assign data_data_i = data_mem[data_addr_o];

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) tag_mem[i] <= '0;
    end else begin
      if (tag_enable_o && tag_write_o)   tag_mem[tag_addr_o]   <= tag_data_o;
      if (data_enable_o && data_write_o) data_mem[data_addr_o] <= data_data_o;
    end
  end

  // Power-on memory image; word 0x101 (byte 0x404) carries a marker value.
  function automatic logic [31:0] init_word(input int unsigned w);
    if (w == 32'h101) return 32'hDEAD_BEEF;
    return (w * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return init_word(w);
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] line_addr);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = ref_word((line_addr >> 2) + i);
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input int unsigned line);
    logic [255:0] l;
    if (mem_store.exists(line)) return mem_store[line];
    for (int i = 0; i < 8; i++) l[32*i +: 32] = init_word(line * 8 + i);
    return l;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Memory responder: acks on the mem_latency-th cycle of each request and
  // compares the request against the next expected memory transaction.
  initial begin
    int       wait_cnt;
    mem_exp_t me;
    wait_cnt   = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack_i = 1'b0;
      if (rst || !mem_enable_o) begin
        wait_cnt = 0;
      end else begin
        wait_cnt++;
        if (wait_cnt >= mem_latency) begin
          wait_cnt  = 0;
          mem_ack_i = 1'b1;
          if (mem_q.size() == 0) begin
            n_compared++;
            n_failed++;
            $display("[TB] FAIL mem_unexpected: got request at %0h, expected none", mem_addr_o);
          end else begin
            me = mem_q.pop_front();
            checkOutput("mem_write", {255'd0, mem_write_o}, {255'd0, me.write});
            checkOutput("mem_addr", {224'd0, mem_addr_o}, {224'd0, me.addr});
            if (me.write) checkOutput("wb_data", mem_data_o, me.data);
          end
          if (mem_write_o) begin
            mem_store[mem_addr_o[31:5]] = mem_data_o;
            last_wb_data = mem_data_o;
          end else begin
            mem_data_i = mem_line(mem_addr_o[31:5]);
          end
        end
      end
    end
  end

  // Monitor: counts stalled cycles of the current request and, in the cycle
  // the stall releases, checks it against the oldest expectation.
  initial begin
    int   stall_cnt;
    exp_t e;
    stall_cnt = 0;
    forever begin
      @(posedge clk);
      #4;
      if (rst) begin
        stall_cnt = 0;
      end else if (p1_MemRead_i || p1_MemWrite_i) begin
        if (p1_stall_o) begin
          stall_cnt++;
        end else begin
          if (exp_q.size() == 0) begin
            n_compared++;
            n_failed++;
            $display("[TB] FAIL cpu_unexpected: got completion at %0h, expected none", p1_addr_i);
          end else begin
            e = exp_q.pop_front();
            if (e.is_load) checkOutput("load_data", {224'd0, p1_data_o}, {224'd0, e.data});
            checkOutput("stall_cycles", stall_cnt, e.stall);
            checkOutput("mem_idle", {255'd0, mem_enable_o}, 256'd0);
          end
          stall_cnt = 0;
        end
      end
    end
  end

  // Reset in the middle of a request: memory request must drop at once,
  // and all cache contents (including dirty lines) are lost.
  task automatic abortWithReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_mem_enable", {255'd0, mem_enable_o}, 256'd0);
    checkOutput("rst_mem_write",  {255'd0, mem_write_o},  256'd0);
    checkOutput("rst_tag_write",  {255'd0, tag_write_o},  256'd0);
    checkOutput("rst_data_write", {255'd0, data_write_o}, 256'd0);
    exp_q.delete();
    mem_q.delete();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    ref_mem = ref_backing;
    @(posedge clk);
    #1;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Issue one CPU request (op 0 load, 1 store, 2 both strobes) and hold it
  // until the stall releases. abort_at > 0 resets the DUT in that ALLOCATE
  // cycle instead. Entered and left at posedge+1.
  task automatic applyStimulus(input int op, input logic [31:0] addr,
                               input logic [31:0] wdata, input int lat,
                               input int abort_at);
    logic [4:0]  idx;
    logic [21:0] tg;
    int unsigned widx;
    bit          hit;
    bit          dirty;
    bit          done;
    int          alloc_seen;
    exp_t        e;
    mem_exp_t    m;

    idx   = addr[9:5];
    tg    = addr[31:10];
    widx  = addr >> 2;
    hit   = m_valid[idx] && (m_tag[idx] == tg);
    dirty = m_valid[idx] && m_dirty[idx];

    e.is_load = (op == 0);
    e.data    = ref_word(widx);
    e.stall   = hit ? 0 : (dirty ? 3 + 2 * lat : 3 + lat);

    if (!hit) begin
      if (dirty) begin
        m.write = 1'b1;
        m.addr  = {m_tag[idx], idx, 5'b00000};
        m.data  = ref_line(m.addr);
        for (int i = 0; i < 8; i++) ref_backing[(m.addr >> 2) + i] = ref_word((m.addr >> 2) + i);
        mem_q.push_back(m);
      end
      m.write = 1'b0;
      m.addr  = {tg, idx, 5'b00000};
      m.data  = '0;
      mem_q.push_back(m);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    if (op != 0) begin
      m_dirty[idx]  = 1'b1;
      ref_mem[widx] = wdata;
    end
    exp_q.push_back(e);

    mem_latency   = lat;
    p1_addr_i     = addr;
    p1_data_i     = wdata;
    p1_MemRead_i  = (op != 1);
    p1_MemWrite_i = (op != 0);

    done       = 1'b0;
    alloc_seen = 0;
    for (int budget = 4 * lat + 30; budget > 0 && !done; budget--) begin
      #2;
      if (!p1_stall_o) begin
        done = 1'b1;
      end else if (abort_at > 0 && mem_enable_o && !mem_write_o) begin
        alloc_seen++;
        if (alloc_seen == abort_at) begin
          abortWithReset();
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_compared++;
      n_failed++;
      $display("[TB] FAIL request_timeout: got stall still high at %0h, expected release", addr);
      exp_q.delete();
      mem_q.delete();
    end
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    rst           = 1'b0;
    p1_addr_i     = '0;
    p1_data_i     = '0;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      data_mem[i] = '0;
      m_valid[i]  = 1'b0;
      m_dirty[i]  = 1'b0;
      m_tag[i]    = '0;
    end

    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_mem_enable", {255'd0, mem_enable_o}, 256'd0);
    checkOutput("reset_mem_write",  {255'd0, mem_write_o},  256'd0);
    checkOutput("reset_tag_write",  {255'd0, tag_write_o},  256'd0);
    checkOutput("reset_data_write", {255'd0, data_write_o}, 256'd0);
    checkOutput("reset_stall",      {255'd0, p1_stall_o},   256'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] cold load miss, hit, store hit");
    applyStimulus(0, 32'h0000_0404, 32'h0, 10, 0);
    applyStimulus(0, 32'h0000_041C, 32'h0, 3, 0);
    applyStimulus(1, 32'h0000_0408, 32'h1234_5678, 3, 0);
    checkOutput("tag_after_store_hit", {232'd0, tag_mem[0]}, {232'd0, 2'b11, 22'd1});
    applyStimulus(0, 32'h0000_0408, 32'h0, 3, 0);

    $display("[TB] conflicting load forces write-back");
    applyStimulus(0, 32'h0000_0808, 32'h0, 4, 0);
    checkOutput("wb_word2", {224'd0, last_wb_data[95:64]}, {224'd0, 32'h1234_5678});

    $display("[TB] store miss on clean line");
    applyStimulus(1, 32'h0000_0C0C, 32'hCAFE_F00D, 2, 0);
    checkOutput("tag_after_store_miss", {232'd0, tag_mem[0]}, {232'd0, 2'b11, 22'd3});
    for (int i = 0; i < 8; i++) applyStimulus(0, 32'h0000_0C00 + 4 * i, 32'h0, 2, 0);

    $display("[TB] reset during allocate, then retry");
    applyStimulus(0, 32'h0000_1010, 32'h0, 10, 4);
    applyStimulus(0, 32'h0000_1010, 32'h0, 3, 0);

    $display("[TB] random traffic");
    for (int n = 0; n < 200; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      a  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 5) |
           ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      applyStimulus((op < 4) ? 0 : ((op < 9) ? 1 : 2), a, $urandom, int'($urandom_range(1, 5)), 0);
    end

    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0 || mem_q.size() != 0) begin
      n_compared++;
      n_failed++;
      $display("[TB] FAIL leftover_expectations: got %0d cpu / %0d mem pending, expected 0",
               exp_q.size(), mem_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
